// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder: FSM states, default device ID,
// byte width and ACK/NACK levels.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVID,
    ACK_ID,
    REGADR,
    ACK_REG,
    WDATA,
    ACK_WD,
    RDATA,
    RD_ACK,
    IGNORE
  } sccb_state_t;

  localparam logic [7:0] DEFAULT_DEV_ID = 8'h42;
  localparam int         BYTE_BITS      = 8;
  localparam logic       ACK            = 1'b0;
  localparam logic       NACK           = 1'b1;

  // Only the 7-bit address takes part in matching; the R/W bit is handled separately.
  function automatic logic id_match(input logic [6:0] rx_addr, input logic [6:0] own_addr);
    return rx_addr == own_addr;
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Brings sioc/siod into the clk_50Mhz domain and derives SCL edge pulses plus
// START/STOP bus conditions from the synchronized lines.
module sccb_line_sync (
  input  logic clk_50Mhz,
  input  logic rst_n,
  input  logic sioc,
  input  logic siod_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync_reg;
  logic [1:0] sda_sync_reg;
  logic       scl_d_reg;
  logic       sda_d_reg;
  logic       scl_s;

  // Reset to the idle-bus level so release of reset never looks like an edge.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], sioc};
      sda_sync_reg <= {sda_sync_reg[0], siod_i};
      scl_d_reg    <= scl_sync_reg[1];
      sda_d_reg    <= sda_sync_reg[1];
    end
  end

  assign scl_s     = scl_sync_reg[1];
  assign sda_s     = sda_sync_reg[1];
  assign scl_rise  = scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s & scl_d_reg;
  assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
  assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

endmodule

// File: rtl/sccb_slave_regfile.sv
// SCCB responder: decodes ID/address/data bytes, issues register-write strobes and
// shifts out read data from an external register bank over an open-drain siod.
module sccb_slave_regfile
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID    = DEFAULT_DEV_ID,
  parameter int         MIN_PHASE = 4
) (
  input  logic       clk_50Mhz,
  input  logic       rst_n,
  input  logic       sioc,
  input  logic       siod_i,
  output logic       siod_oe,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  if (MIN_PHASE < 4) begin : g_min_phase_check
    $error("sccb_slave_regfile: MIN_PHASE below 4 leaves no margin for siod_oe timing");
  end

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  sccb_line_sync u_line_sync (
    .clk_50Mhz (clk_50Mhz),
    .rst_n     (rst_n),
    .sioc      (sioc),
    .siod_i    (siod_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  sccb_state_t state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic        wr_reg, wr_next;
  logic        oe_reg, oe_next;
  logic        rw_reg, rw_next;

  logic [7:0]  rx_byte;
  logic        last_bit;

  assign rx_byte  = {shift_reg[6:0], sda_s};
  assign last_bit = (bit_cnt_reg == 4'(BYTE_BITS - 1));

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 8'd0;
      addr_reg    <= 8'd0;
      wdata_reg   <= 8'd0;
      wr_reg      <= 1'b0;
      oe_reg      <= 1'b0;
      rw_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wr_reg      <= wr_next;
      oe_reg      <= oe_next;
      rw_reg      <= rw_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wr_next      = 1'b0;
    oe_next      = oe_reg;
    rw_next      = rw_reg;

    // Post-write auto-increment lands the cycle after the strobe.
    if (wr_reg) addr_next = addr_reg + 8'd1;

    if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = 4'd0;
      oe_next      = 1'b0;
    end else if (start_det) begin
      state_next   = DEVID;
      bit_cnt_next = 4'd0;
      oe_next      = 1'b0;
    end else begin
      case (state_reg)
        IDLE: ;
        DEVID: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (last_bit) begin
              bit_cnt_next = 4'd0;
              if (id_match(rx_byte[7:1], DEV_ID[7:1])) begin
                rw_next    = rx_byte[0];
                state_next = ACK_ID;
              end else begin
                state_next = IGNORE;
              end
            end
          end
        end
        // In ACK slots oe_reg doubles as the phase flag: first fall drives, second releases.
        ACK_ID: begin
          if (scl_fall) begin
            if (!oe_reg) begin
              oe_next = 1'b1;
            end else if (rw_reg) begin
              shift_next = reg_rdata;
              oe_next    = ~reg_rdata[7];
              state_next = RDATA;
            end else begin
              oe_next    = 1'b0;
              state_next = REGADR;
            end
          end
        end
        REGADR: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (last_bit) begin
              bit_cnt_next = 4'd0;
              addr_next    = rx_byte;
              state_next   = ACK_REG;
            end
          end
        end
        ACK_REG: begin
          if (scl_fall) begin
            oe_next = ~oe_reg;
            if (oe_reg) state_next = WDATA;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (last_bit) begin
              bit_cnt_next = 4'd0;
              wdata_next   = rx_byte;
              wr_next      = 1'b1;
              state_next   = ACK_WD;
            end
          end
        end
        ACK_WD: begin
          if (scl_fall) begin
            oe_next = ~oe_reg;
            if (oe_reg) state_next = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_reg == 4'(BYTE_BITS)) begin
              bit_cnt_next = 4'd0;
              oe_next      = 1'b0;
              addr_next    = addr_reg + 8'd1;
              state_next   = RD_ACK;
            end else begin
              shift_next = {shift_reg[6:0], 1'b0};
              oe_next    = ~shift_reg[6];
            end
          end
        end
        // bit_cnt_reg=1 marks that the master acknowledged and another byte follows.
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK) state_next   = IGNORE;
            else               bit_cnt_next = 4'd1;
          end else if (scl_fall && bit_cnt_reg == 4'd1) begin
            bit_cnt_next = 4'd0;
            shift_next   = reg_rdata;
            oe_next      = ~reg_rdata[7];
            state_next   = RDATA;
          end
        end
        IGNORE: ;
        default: state_next = IDLE;
      endcase
    end
  end

  assign siod_oe   = oe_reg;
  assign reg_wr    = wr_reg;
  assign reg_addr  = addr_reg;
  assign reg_wdata = wdata_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Directed bench: a behavioural SCCB master at 200 kHz drives write, read, burst,
// mismatched-ID, early-STOP and mid-ACK reset transactions against the responder.
module tb_sccb_slave_regfile;

  localparam int Q = 1250;  // quarter SCL period (clock period is 20)

  logic       clk_50Mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       sioc      = 1'b1;
  logic       m_sda     = 1'b1;
  logic       siod_i;
  logic       siod_oe;
  logic       reg_wr;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  int         wr_total  = 0;
  int         wr_high   = 0;
  int         oe_cycles = 0;
  logic       wr_prev   = 1'b0;
  logic [7:0] wr_addr_log [16];
  logic [7:0] wr_data_log [16];

  always #10 clk_50Mhz = ~clk_50Mhz;

  // Open-drain line with pull-up: low if either side pulls it low.
  assign siod_i    = m_sda & ~siod_oe;
  assign reg_rdata = (reg_addr == 8'h0A) ? 8'h76 : 8'hC3;

  sccb_slave_regfile dut (
    .clk_50Mhz (clk_50Mhz),
    .rst_n     (rst_n),
    .sioc      (sioc),
    .siod_i    (siod_i),
    .siod_oe   (siod_oe),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always @(negedge clk_50Mhz) begin
    if (reg_wr) begin
      wr_high = wr_high + 1;
      if (!wr_prev) begin
        wr_addr_log[wr_total % 16] = reg_addr;
        wr_data_log[wr_total % 16] = reg_wdata;
        wr_total = wr_total + 1;
      end
    end
    wr_prev = reg_wr;
    if (siod_oe) oe_cycles = oe_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_start();
    m_sda = 1'b1; sioc = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    sioc  = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q;
    sioc  = 1'b1; #Q;
    m_sda = 1'b1; #(2*Q);
  endtask

  task automatic bus_bit(input logic b, output logic seen);
    m_sda = b; #Q;
    sioc  = 1'b1; #Q;
    seen  = siod_i; #Q;
    sioc  = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], dummy);
    bus_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic bit_v;
    logic dummy;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, bit_v);
      d[i] = bit_v;
    end
    bus_bit(master_ack, dummy);
  endtask

  initial begin
    logic       a0, a1, a2, a3;
    logic [7:0] rd;
    int         base_wr, base_high, base_oe;

    #55;
    check_eq("rst_siod_oe", 16'(siod_oe), 16'h0);
    check_eq("rst_reg_wr", 16'(reg_wr), 16'h0);
    check_eq("rst_reg_addr", 16'(reg_addr), 16'h00);
    check_eq("rst_reg_wdata", 16'(reg_wdata), 16'h00);
    check_eq("rst_busy", 16'(busy), 16'h0);
    rst_n = 1'b1;
    #(4*Q);

    // Single write 42/12/80
    base_wr = wr_total; base_high = wr_high;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h12, a1);
    send_byte(8'h80, a2);
    check_eq("wr_ack_id", 16'(a0), 16'h0);
    check_eq("wr_ack_reg", 16'(a1), 16'h0);
    check_eq("wr_ack_data", 16'(a2), 16'h0);
    check_eq("wr_busy_before_stop", 16'(busy), 16'h1);
    bus_stop();
    check_eq("wr_busy_after_stop", 16'(busy), 16'h0);
    check_eq("wr_strobe_count", 16'(wr_total - base_wr), 16'd1);
    check_eq("wr_strobe_width", 16'(wr_high - base_high), 16'd1);
    check_eq("wr_addr", 16'(wr_addr_log[base_wr % 16]), 16'h12);
    check_eq("wr_data", 16'(wr_data_log[base_wr % 16]), 16'h80);
    check_eq("wr_addr_incr", 16'(reg_addr), 16'h13);
    $display("txn write 42/12/80 addr=%0h data=%0h", wr_addr_log[base_wr % 16], wr_data_log[base_wr % 16]);

    // Mismatched device ID 60/12/80
    base_wr = wr_total; base_oe = oe_cycles;
    bus_start();
    send_byte(8'h60, a0);
    send_byte(8'h12, a1);
    send_byte(8'h80, a2);
    check_eq("mis_no_ack_id", 16'(a0), 16'h1);
    check_eq("mis_no_ack_data", 16'(a2), 16'h1);
    check_eq("mis_busy_ignore", 16'(busy), 16'h1);
    bus_stop();
    check_eq("mis_oe_cycles", 16'(oe_cycles - base_oe), 16'd0);
    check_eq("mis_strobe_count", 16'(wr_total - base_wr), 16'd0);
    check_eq("mis_idle", 16'(busy), 16'h0);
    check_eq("mis_addr_kept", 16'(reg_addr), 16'h13);
    $display("txn mismatch 60/12/80 ack_id=%0b", a0);

    // Set pointer 0A, then read one byte with NACK
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h0A, a1);
    bus_stop();
    check_eq("rd_ptr_set", 16'(reg_addr), 16'h0A);
    bus_start();
    send_byte(8'h43, a2);
    check_eq("rd_ack_id", 16'(a2), 16'h0);
    recv_byte(1'b1, rd);
    check_eq("rd_data", 16'(rd), 16'h76);
    bus_stop();
    check_eq("rd_addr_after", 16'(reg_addr), 16'h0B);
    check_eq("rd_busy_after", 16'(busy), 16'h0);
    $display("txn read 43 at 0A data=%0h", rd);

    // Burst write across the pointer wrap 42/FF/11/22
    base_wr = wr_total; base_high = wr_high;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'hFF, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    bus_stop();
    check_eq("burst_acks", 16'({a0, a1, a2, a3}), 16'h0);
    check_eq("burst_count", 16'(wr_total - base_wr), 16'd2);
    check_eq("burst_width", 16'(wr_high - base_high), 16'd2);
    check_eq("burst_addr0", 16'(wr_addr_log[base_wr % 16]), 16'hFF);
    check_eq("burst_data0", 16'(wr_data_log[base_wr % 16]), 16'h11);
    check_eq("burst_addr1", 16'(wr_addr_log[(base_wr + 1) % 16]), 16'h00);
    check_eq("burst_data1", 16'(wr_data_log[(base_wr + 1) % 16]), 16'h22);
    check_eq("burst_addr_after", 16'(reg_addr), 16'h01);
    $display("txn burst 42/FF/11/22 strobes=%0d", wr_total - base_wr);

    // STOP right after the register byte
    base_wr = wr_total;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h05, a1);
    bus_stop();
    check_eq("early_stop_no_wr", 16'(wr_total - base_wr), 16'd0);
    check_eq("early_stop_addr", 16'(reg_addr), 16'h05);
    $display("txn pointer-only 42/05 addr=%0h", reg_addr);

    // Reset in the middle of the ACK_REG slot
    bus_start();
    send_byte(8'h42, a0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] pat;
      logic dummy;
      pat = 8'h33;
      bus_bit(pat[i], dummy);
    end
    m_sda = 1'b1; #Q;
    sioc  = 1'b1; #Q;
    check_eq("ackreg_oe_driven", 16'(siod_oe), 16'h1);
    @(negedge clk_50Mhz);
    #2 rst_n = 1'b0;
    #2;
    check_eq("async_rst_oe", 16'(siod_oe), 16'h0);
    check_eq("async_rst_addr", 16'(reg_addr), 16'h00);
    check_eq("async_rst_wdata", 16'(reg_wdata), 16'h00);
    check_eq("async_rst_wr", 16'(reg_wr), 16'h0);
    check_eq("async_rst_busy", 16'(busy), 16'h0);
    #100 rst_n = 1'b1;
    #Q; sioc = 1'b0; #Q;
    bus_stop();
    base_wr = wr_total;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h20, a1);
    send_byte(8'h5A, a2);
    bus_stop();
    check_eq("post_rst_acks", 16'({a0, a1, a2}), 16'h0);
    check_eq("post_rst_count", 16'(wr_total - base_wr), 16'd1);
    check_eq("post_rst_addr", 16'(wr_addr_log[base_wr % 16]), 16'h20);
    check_eq("post_rst_data", 16'(wr_data_log[base_wr % 16]), 16'h5A);
    $display("txn reset-recovery write 42/20/5A strobes=%0d", wr_total - base_wr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
